// File: rtl/fifo_push_packer_4w_pkg.sv
// Shared definitions for 4-write FIFO producers: lane count, staging count type,
// downstream space decode and push thermometer helpers.
package fifo_push_packer_4w_pkg;

  localparam int LANES = 4;

  typedef logic [2:0] cnt_t;

  // When several space flags assert, the most pessimistic one wins.
  function automatic cnt_t space_decode(input logic full,
                                        input logic left1,
                                        input logic left2,
                                        input logic left3);
    cnt_t s;
    if (full)       s = 3'd0;
    else if (left1) s = 3'd1;
    else if (left2) s = 3'd2;
    else if (left3) s = 3'd3;
    else            s = 3'd4;
    return s;
  endfunction

  function automatic logic [LANES-1:0] therm4(input cnt_t n);
    logic [LANES-1:0] t;
    case (n)
      3'd0:    t = 4'b0000;
      3'd1:    t = 4'b0001;
      3'd2:    t = 4'b0011;
      3'd3:    t = 4'b0111;
      default: t = 4'b1111;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fifo_push_packer_4w_if.sv
// Upstream beat and downstream 4-write FIFO signals of fifo_push_packer_4w.
// master = environment (upstream source + FIFO), slave = the packer.
interface fifo_push_packer_4w_if #(parameter int DWIDTH = 32);

  // Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
  // in_lane_vld/in_data* are only meaningful while in_valid is high, and the FIFO
  // captures inData_i on every edge where push_i is high.
  logic              in_valid;
  logic [3:0]        in_lane_vld;
  logic [DWIDTH-1:0] in_data0;
  logic [DWIDTH-1:0] in_data1;
  logic [DWIDTH-1:0] in_data2;
  logic [DWIDTH-1:0] in_data3;
  logic              in_ready;

  logic              push0;
  logic              push1;
  logic              push2;
  logic              push3;
  logic [DWIDTH-1:0] inData0;
  logic [DWIDTH-1:0] inData1;
  logic [DWIDTH-1:0] inData2;
  logic [DWIDTH-1:0] inData3;

  logic              fifo_full;
  logic              fifo_1left_to_full;
  logic              fifo_2left_to_full;
  logic              fifo_3left_to_full;

  modport master (
    output in_valid, in_lane_vld, in_data0, in_data1, in_data2, in_data3,
    output fifo_full, fifo_1left_to_full, fifo_2left_to_full, fifo_3left_to_full,
    input  in_ready, push0, push1, push2, push3,
    input  inData0, inData1, inData2, inData3
  );

  modport slave (
    input  in_valid, in_lane_vld, in_data0, in_data1, in_data2, in_data3,
    input  fifo_full, fifo_1left_to_full, fifo_2left_to_full, fifo_3left_to_full,
    output in_ready, push0, push1, push2, push3,
    output inData0, inData1, inData2, inData3
  );

endinterface

// File: rtl/edff.sv
// Enabled D flip-flop with asynchronous active-low reset to zero.
module edff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/lane_compact4.sv
// Packs the valid lanes of a 4-lane beat into slots 0..k-1 in ascending lane
// order and reports k; unused slots read zero.
module lane_compact4
  import fifo_push_packer_4w_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [LANES-1:0]             mask,
  input  logic [LANES-1:0][DWIDTH-1:0] lane_data,
  output logic [LANES-1:0][DWIDTH-1:0] slot_data,
  output cnt_t                         count
);

  always_comb begin
    slot_data = '0;
    count     = '0;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) begin
        slot_data[count[1:0]] = lane_data[l];
        count                 = count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_packer_4w.sv
// Compacts sparse 4-lane beats into a staging buffer and drains it into a 4-write
// FIFO as thermometer pushes. Define FIFO_PUSH_PACKER_PERF_EN for the stall counter.
module fifo_push_packer_4w
  import fifo_push_packer_4w_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_push_packer_4w_if.slave  bus,
  output logic [15:0]           stall_cnt
);

  logic [LANES-1:0][DWIDTH-1:0] lane_data;
  logic [LANES-1:0][DWIDTH-1:0] comp_data;
  logic [DWIDTH-1:0]            slot_q [LANES];
  logic [DWIDTH-1:0]            slot_d [LANES];
  logic [LANES-1:0]             slot_en;
  logic [LANES-1:0]             push;
  cnt_t                         comp_cnt;
  cnt_t                         cnt_q;
  cnt_t                         cnt_d;
  cnt_t                         space;
  cnt_t                         n;
  cnt_t                         rem;
  cnt_t                         src;
  logic                         accept;

  assign lane_data = {bus.in_data3, bus.in_data2, bus.in_data1, bus.in_data0};

  lane_compact4 #(.DWIDTH(DWIDTH)) u_compact (
    .mask      (bus.in_lane_vld),
    .lane_data (lane_data),
    .slot_data (comp_data),
    .count     (comp_cnt)
  );

  assign space = space_decode(bus.fifo_full, bus.fifo_1left_to_full,
                              bus.fifo_2left_to_full, bus.fifo_3left_to_full);
  assign n     = (cnt_q < space) ? cnt_q : space;
  assign rem   = cnt_q - n;

  // A new beat loads on the same edge the last staged entries leave.
  assign bus.in_ready = (rem == 3'd0);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = therm4(n);

  always_comb begin
    slot_d  = slot_q;
    slot_en = '0;
    src     = '0;
    cnt_d   = accept ? comp_cnt : rem;
    for (int j = 0; j < LANES; j++) begin
      src = 3'(j) + n;
      if (accept) begin
        if (3'(j) < comp_cnt) begin
          slot_d[j]  = comp_data[j];
          slot_en[j] = 1'b1;
        end
      end else if (n != 3'd0 && src < 3'd4) begin
        slot_d[j]  = slot_q[src[1:0]];
        slot_en[j] = 1'b1;
      end
    end
  end

  edff #(.W(3)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .d     (cnt_d),
    .q     (cnt_q)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_slot
    edff #(.W(DWIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (slot_en[g]),
      .d     (slot_d[g]),
      .q     (slot_q[g])
    );
  end

  assign bus.push0   = push[0];
  assign bus.push1   = push[1];
  assign bus.push2   = push[2];
  assign bus.push3   = push[3];
  assign bus.inData0 = slot_q[0];
  assign bus.inData1 = slot_q[1];
  assign bus.inData2 = slot_q[2];
  assign bus.inData3 = slot_q[3];

`ifdef FIFO_PUSH_PACKER_PERF_EN
  logic [15:0] stall_q;

  // A cycle stalls whenever entries remain staged after this cycle's pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stall_q <= '0;
    else if (rem != 3'd0 && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

`ifdef ASSERT_ON
  a_push_therm: assert property (@(posedge clk) disable iff (!rst_n)
    push inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});
  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= 3'd4);
`endif

endmodule

// File: tb/tb_fifo_push_packer_4w.sv
// Randomized and directed bench for fifo_push_packer_4w against a queue-based
// model of the staged entries.
module tb_fifo_push_packer_4w;

`ifdef FIFO_PUSH_PACKER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_push_packer_4w_if #(.DWIDTH(32)) bus();
  logic [15:0] stall_cnt;

  fifo_push_packer_4w #(.DWIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  logic [31:0] lane_d [4];
  logic [31:0] out_d  [4];
  logic [3:0]  push_v;

  assign bus.in_data0 = lane_d[0];
  assign bus.in_data1 = lane_d[1];
  assign bus.in_data2 = lane_d[2];
  assign bus.in_data3 = lane_d[3];
  assign out_d[0] = bus.inData0;
  assign out_d[1] = bus.inData1;
  assign out_d[2] = bus.inData2;
  assign out_d[3] = bus.inData3;
  assign push_v   = {bus.push3, bus.push2, bus.push1, bus.push0};

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];   // entries accepted but not yet pushed, in FIFO order
  int          exp_stall;
  int          n_vec;
  int          n_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic valid, input logic [3:0] mask,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
    bus.in_valid    = valid;
    bus.in_lane_vld = mask;
    lane_d[0] = d0; lane_d[1] = d1; lane_d[2] = d2; lane_d[3] = d3;
  endtask

  task automatic set_flags(input logic [3:0] f);  // {3left, 2left, 1left, full}
    bus.fifo_full          = f[0];
    bus.fifo_1left_to_full = f[1];
    bus.fifo_2left_to_full = f[2];
    bus.fifo_3left_to_full = f[3];
  endtask

  // One clock: check outputs against the model at negedge, then advance the model.
  task automatic step();
    int sz, spc, n;
    logic [3:0] exp_push;
    @(negedge clk);
    spc = 4;
    if (bus.fifo_3left_to_full && spc > 3) spc = 3;
    if (bus.fifo_2left_to_full && spc > 2) spc = 2;
    if (bus.fifo_1left_to_full && spc > 1) spc = 1;
    if (bus.fifo_full) spc = 0;
    sz = exp_q.size();
    n  = (sz < spc) ? sz : spc;
    exp_push = 4'((1 << n) - 1);
    check_eq("push", 64'(push_v), 64'(exp_push));
    for (int i = 0; i < n; i++) check_eq($sformatf("inData%0d", i), 64'(out_d[i]), 64'(exp_q[i]));
    check_eq("in_ready", 64'(bus.in_ready), 64'((sz - n) == 0));
    check_eq("stall_cnt", 64'(stall_cnt), PERF ? 64'(exp_stall) : 64'd0);
    if ((sz - n) != 0 && exp_stall < 65535) exp_stall++;
    for (int i = 0; i < n; i++) void'(exp_q.pop_front());
    if (bus.in_valid && (sz - n) == 0)
      for (int l = 0; l < 4; l++) if (bus.in_lane_vld[l]) exp_q.push_back(lane_d[l]);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive_beat(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #2;
    check_eq("rst_push", 64'(push_v), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check_eq($sformatf("rst_inData%0d", i), 64'(out_d[i]), 64'd0);
    check_eq("rst_push_clk", 64'(push_v), 64'd0);
    exp_q.delete();
    exp_stall = 0;
    set_flags(4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    exp_stall = 0;
    set_flags(4'h0);
    apply_reset();

    // Sparse beat into an empty FIFO.
    drive_beat(1'b1, 4'b1010, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
    step();
    drive_beat(1'b0, 4'b1111, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    step();

    // Full beat with only two slots free, then space for four.
    drive_beat(1'b1, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    set_flags(4'b0100);
    step();
    drive_beat(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    set_flags(4'h0);
    step();

    // Three entries held by a full FIFO for five cycles, then released.
    drive_beat(1'b1, 4'b0111, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
    set_flags(4'b0001);
    step();
    drive_beat(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (5) step();
    set_flags(4'h0);
    step();
    step();

    // Back-to-back beats, empty beat and flag priority.
    drive_beat(1'b1, 4'b0001, 32'hC0, 32'hC1, 32'hC2, 32'hC3); step();
    drive_beat(1'b1, 4'b0110, 32'hE0, 32'hE1, 32'hE2, 32'hE3); step();
    drive_beat(1'b1, 4'b1111, 32'hF0, 32'hF1, 32'hF2, 32'hF3); step();
    drive_beat(1'b1, 4'b0000, 32'h10, 32'h11, 32'h12, 32'h13); step();
    drive_beat(1'b1, 4'b1111, 32'h20, 32'h21, 32'h22, 32'h23);
    set_flags(4'b1010);
    step();
    drive_beat(1'b0, 4'b1111, 32'h30, 32'h31, 32'h32, 32'h33);
    repeat (4) step();
    set_flags(4'h0);

    // Reset while two entries are staged behind a full FIFO.
    drive_beat(1'b1, 4'b0011, 32'h40, 32'h41, 32'h42, 32'h43);
    set_flags(4'b0001);
    step();
    drive_beat(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    apply_reset();
    repeat (3) step();

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 3000; c++) begin
      drive_beat(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 $urandom, $urandom, $urandom, $urandom);
      set_flags({1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0)});
      step();
    end
    drive_beat(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    set_flags(4'h0);
    repeat (3) step();

    // Long stall to drive the counter into saturation.
    apply_reset();
    drive_beat(1'b1, 4'b1111, 32'h50, 32'h51, 32'h52, 32'h53);
    set_flags(4'b0001);
    step();
    drive_beat(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (70000) step();
    check_eq("stall_sat", 64'(stall_cnt), PERF ? 64'hFFFF : 64'd0);
    set_flags(4'h0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
